grf_hazard_scoreboard: RTL and testbench

- Per-register scoreboard that sequences access to the 32x32 general register file in the 5-stage pipeline.
- Sits beside the decode stage. Tracks remaining cycles until each in-flight destination value becomes forwardable.
- Compares that against the read-operand need time (Tuse) of the instruction in D, and drives the pipeline stall plus per-operand forward-required hints.

---
 rtl/grf_hazard_scoreboard_if.sv | 55 +++++
 rtl/grf_hazard_scoreboard.sv | 91 +++++++++
 tb/tb_grf_hazard_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : grf_hazard_scoreboard_if
// Brief    : Decode-side bundle between the D stage and the GRF hazard
//            scoreboard; stats signals exist only with GRF_SB_STATS_EN.
// Revision : 1.0
// ============================================================================
interface grf_hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 2
);
  logic          issue_valid;
  logic          issue_we;
  logic [AW-1:0] issue_wa;
  logic [TW-1:0] issue_tnew;
  logic [AW-1:0] rs_addr;
  logic [TW-1:0] rs_tuse;
  logic [AW-1:0] rt_addr;
  logic [TW-1:0] rt_tuse;
  logic          flush;
  logic          stall;
  logic          rs_fwd;
  logic          rt_fwd;
  logic          busy_any;

`ifdef GRF_SB_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   issue_count;

  modport master (
    output issue_valid, issue_we, issue_wa, issue_tnew,
    output rs_addr, rs_tuse, rt_addr, rt_tuse, flush,
    input  stall, rs_fwd, rt_fwd, busy_any, stall_cycles, issue_count
  );

  modport slave (
    input  issue_valid, issue_we, issue_wa, issue_tnew,
    input  rs_addr, rs_tuse, rt_addr, rt_tuse, flush,
    output stall, rs_fwd, rt_fwd, busy_any, stall_cycles, issue_count
  );
`else
  modport master (
    output issue_valid, issue_we, issue_wa, issue_tnew,
    output rs_addr, rs_tuse, rt_addr, rt_tuse, flush,
    input  stall, rs_fwd, rt_fwd, busy_any
  );

  modport slave (
    input  issue_valid, issue_we, issue_wa, issue_tnew,
    input  rs_addr, rs_tuse, rt_addr, rt_tuse, flush,
    output stall, rs_fwd, rt_fwd, busy_any
  );
`endif
endinterface
`default_nettype wire

// File: rtl/grf_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : grf_hazard_scoreboard
// Brief    : Per-register Tnew countdown vs. Tuse stall/forward scoreboard.
//            Optional macro GRF_SB_STATS_EN adds stall/issue statistics.
// Revision : 1.0
// ============================================================================
module grf_hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int TW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  grf_hazard_scoreboard_if.slave sb
);

  logic [TW-1:0]           cnt_q [1:NREG-1];
  logic [NREG-1:0][TW-1:0] cnt_view;
  logic [TW-1:0]           rs_cnt;
  logic [TW-1:0]           rt_cnt;
  logic                    rs_fwd;
  logic                    rt_fwd;
  logic                    stall;
  logic                    fire;

  // Register 0 has no counter; its view slot is tied to zero.
  always_comb begin
    cnt_view = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_view[r] = cnt_q[r];
    end
  end

  assign rs_cnt = cnt_view[sb.rs_addr];
  assign rt_cnt = cnt_view[sb.rt_addr];
  assign rs_fwd = (sb.rs_addr != '0) && (rs_cnt != '0);
  assign rt_fwd = (sb.rt_addr != '0) && (rt_cnt != '0);
  assign stall  = sb.issue_valid &&
                  ((rs_fwd && (rs_cnt > sb.rs_tuse)) ||
                   (rt_fwd && (rt_cnt > sb.rt_tuse)));
  assign fire   = sb.issue_valid && !stall && !sb.flush;

  assign sb.rs_fwd   = rs_fwd;
  assign sb.rt_fwd   = rt_fwd;
  assign sb.stall    = stall;
  assign sb.busy_any = |cnt_view;

  // Flush beats issue, issue beats decrement; loaded value is the newest producer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (sb.flush) begin
          cnt_q[r] <= '0;
        end else if (fire && sb.issue_we && (sb.issue_wa == AW'(r))) begin
          cnt_q[r] <= sb.issue_tnew;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - TW'(1);
        end
      end
    end
  end

`ifdef GRF_SB_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] issue_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      issue_count_q  <= '0;
    end else begin
      if (stall && !sb.flush && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (fire && (issue_count_q != '1)) begin
        issue_count_q <= issue_count_q + 32'd1;
      end
    end
  end

  assign sb.stall_cycles = stall_cycles_q;
  assign sb.issue_count  = issue_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_hazard_scoreboard
// Brief    : Directed scenarios plus random traffic against a ready-time model.
// Revision : 1.0
// ============================================================================
module tb_grf_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int TW   = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Model: absolute cycle at which each register's value becomes forwardable.
  int   ready [NREG];
  int   now;
  int   m_stall_cycles;
  int   m_issue_count;

  grf_hazard_scoreboard_if #(.AW(AW), .TW(TW)) sb();

  grf_hazard_scoreboard #(.NREG(NREG), .AW(AW), .TW(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rem(input int r);
    if (r == 0) return 0;
    return (ready[r] > now) ? (ready[r] - now) : 0;
  endfunction

  function automatic bit m_stall();
    return sb.issue_valid &&
           ((rem(int'(sb.rs_addr)) > int'(sb.rs_tuse)) ||
            (rem(int'(sb.rt_addr)) > int'(sb.rt_tuse)));
  endfunction

  function automatic logic [3:0] m_outs();
    bit busy;
    busy = 1'b0;
    for (int r = 1; r < NREG; r++) if (rem(r) != 0) busy = 1'b1;
    return {m_stall(), rem(int'(sb.rs_addr)) != 0, rem(int'(sb.rt_addr)) != 0, busy};
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) ready[r] = 0;
    m_stall_cycles = 0;
    m_issue_count  = 0;
  endfunction

  task automatic drive(input bit v, input bit we, input int wa, input int tnew,
                       input int rs, input int rs_t, input int rt, input int rt_t,
                       input bit fl);
    sb.issue_valid = v;
    sb.issue_we    = we;
    sb.issue_wa    = AW'(wa);
    sb.issue_tnew  = TW'(tnew);
    sb.rs_addr     = AW'(rs);
    sb.rs_tuse     = TW'(rs_t);
    sb.rt_addr     = AW'(rt);
    sb.rt_tuse     = TW'(rt_t);
    sb.flush       = fl;
    #1;
  endtask

  // One clock edge; the model is advanced with the inputs held across the edge.
  task automatic tick();
    bit st;
    bit f;
    st = m_stall();
    f  = sb.issue_valid && !st && !sb.flush;
    @(posedge clk);
    if (reset) begin
      if (sb.flush) begin
        for (int r = 0; r < NREG; r++) ready[r] = 0;
      end else if (f && sb.issue_we && (sb.issue_wa != '0)) begin
        ready[int'(sb.issue_wa)] = now + 1 + int'(sb.issue_tnew);
      end
      if (st && !sb.flush) m_stall_cycles++;
      if (f) m_issue_count++;
    end
    now++;
    @(negedge clk);
  endtask

  function automatic logic [3:0] outs();
    return {sb.stall, sb.rs_fwd, sb.rt_fwd, sb.busy_any};
  endfunction

  task automatic test_reset();
    logic [3:0] obs;
    reset = 1'b0;
    drive(1, 0, 0, 0, 8, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL reset_hold: got %b want 0000", obs); end
    tick();
    reset = 1'b1;
    drive(1, 1, 8, 3, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 8, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0101) begin n_fail++; $display("FAIL reset_load3: got %b want 0101", obs); end
    tick();
    drive(1, 0, 0, 0, 8, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b1101) begin n_fail++; $display("FAIL reset_pre: got %b want 1101", obs); end
    reset = 1'b0;
    #1;
    model_clear();
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL reset_async: got %b want 0000", obs); end
    tick();
    reset = 1'b1;
    drive(1, 0, 0, 0, 8, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL reset_after: got %b want 0000", obs); end
    tick();
  endtask

  task automatic test_load_use();
    logic [3:0] obs;
    logic [3:0] exp_q[$];
    // Tnew=2, Tuse=0: stalls cnt-Tuse = 2 cycles.
    drive(1, 1, 8, 2, 0, 0, 0, 0, 0);
    tick();
    exp_q = '{4'b1101, 4'b1101, 4'b0000};
    foreach (exp_q[i]) begin
      drive(1, 0, 0, 0, 8, 0, 0, 0, 0);
      obs = outs(); n_checks++;
      if (obs !== exp_q[i]) begin n_fail++; $display("FAIL load_use_t0[%0d]: got %b want %b", i, obs, exp_q[i]); end
      tick();
    end
    // Tuse=1: one stall, then forwarding without stall.
    drive(1, 1, 8, 2, 0, 0, 0, 0, 0);
    tick();
    exp_q = '{4'b1101, 4'b0101, 4'b0000};
    foreach (exp_q[i]) begin
      drive(1, 0, 0, 0, 8, 1, 0, 0, 0);
      obs = outs(); n_checks++;
      if (obs !== exp_q[i]) begin n_fail++; $display("FAIL load_use_t1[%0d]: got %b want %b", i, obs, exp_q[i]); end
      tick();
    end
  endtask

  task automatic test_alu_no_stall();
    logic [3:0] obs;
    drive(1, 1, 9, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0011) begin n_fail++; $display("FAIL alu_fwd: got %b want 0011", obs); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 9, 1, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL alu_done: got %b want 0000", obs); end
    tick();
  endtask

  task automatic test_waw();
    logic [3:0] obs;
    drive(1, 1, 5, 3, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 5, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 5, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b1101) begin n_fail++; $display("FAIL waw_stall: got %b want 1101", obs); end
    tick();
    drive(1, 0, 0, 0, 5, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL waw_release: got %b want 0000", obs); end
    tick();
  endtask

  task automatic test_zero_reg();
    logic [3:0] obs;
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL zero_reg: got %b want 0000", obs); end
    tick();
  endtask

  task automatic test_self_dep();
    logic [3:0] obs;
    // Producer and consumer of $7 in the same D instruction: no older producer.
    drive(1, 1, 7, 3, 7, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL self_dep: got %b want 0000", obs); end
    tick();
    drive(0, 0, 0, 0, 7, 0, 0, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0101) begin n_fail++; $display("FAIL self_dep_load: got %b want 0101", obs); end
    for (int i = 0; i < 3; i++) tick();
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL self_dep_drain: got %b want 0000", obs); end
  endtask

  task automatic test_flush();
    logic [3:0] obs;
    drive(1, 1, 3, 3, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 4, 2, 3, 0, 0, 0, 1);
    obs = outs(); n_checks++;
    if (obs !== 4'b1101) begin n_fail++; $display("FAIL flush_cycle: got %b want 1101", obs); end
    tick();
    drive(1, 0, 0, 0, 3, 0, 4, 0, 0);
    obs = outs(); n_checks++;
    if (obs !== 4'b0000) begin n_fail++; $display("FAIL flush_clear: got %b want 0000", obs); end
`ifdef GRF_SB_STATS_EN
    n_checks++;
    if (sb.stall_cycles !== 32'(m_stall_cycles)) begin
      n_fail++; $display("FAIL flush_stall_cycles: got %0d want %0d", sb.stall_cycles, m_stall_cycles);
    end
    n_checks++;
    if (sb.issue_count !== 32'(m_issue_count)) begin
      n_fail++; $display("FAIL flush_issue_count: got %0d want %0d", sb.issue_count, m_issue_count);
    end
`endif
    tick();
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
  endfunction

  task automatic test_random();
    logic [3:0] obs;
    logic [3:0] exp;
    int         errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, pick_reg(),
            int'($urandom_range(0, 3)), pick_reg(), int'($urandom_range(0, 3)),
            pick_reg(), int'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
      obs = outs();
      exp = m_outs();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random[%0d]: got %b want %b", i, obs, exp);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef GRF_SB_STATS_EN
    n_checks++;
    if (sb.stall_cycles !== 32'(m_stall_cycles)) begin
      n_fail++; $display("FAIL random_stall_cycles: got %0d want %0d", sb.stall_cycles, m_stall_cycles);
    end
    n_checks++;
    if (sb.issue_count !== 32'(m_issue_count)) begin
      n_fail++; $display("FAIL random_issue_count: got %0d want %0d", sb.issue_count, m_issue_count);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    now      = 0;
    model_clear();
    reset    = 1'b0;
    test_reset();
    test_load_use();
    test_alu_no_stall();
    test_waw();
    test_zero_reg();
    test_self_dep();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
